// File: rtl/block_r_update.sv
// Residual update writer: r[k] := sat(r[k] - (coef * phi_lambda[k]) >>> FRAC)
// for rows 0..M. It reads phi column lambda and the residual, and writes the
// updated rows back through r_bram port A at one row per cycle.
//
// state   | meaning
// S_IDLE  | waiting for start_c
// S_RUN   | issuing phi/r read addresses for rows 0..M
// S_DRAIN | no more reads; waiting until the last row's write is presented
// S_DONE  | one cycle that registers the done pulse, then back to idle
module block_r_update #(
    parameter int LANES = 6,
    parameter int LW    = 16,
    parameter int FRAC  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_c,
    input  logic [5:0]            N,
    input  logic [2:0]            M,
    input  logic [5:0]            lambda,
    input  logic [15:0]           coef,
    output logic [8:0]            phi_addr,
    input  logic [LANES*LW-1:0]   phi_data,
    output logic [2:0]            r_rd_addr,
    input  logic [LANES*LW-1:0]   r_rd_data,
    output logic [2:0]            r_wr_addr,
    output logic [LANES*LW-1:0]   r_wr_data,
    output logic                  r_we,
    output logic                  busy,
    output logic                  err,
    output logic                  block_r_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state;
    logic [5:0]          lambda_q;
    logic [15:0]         coef_q;
    logic [2:0]          m_q;
    logic [2:0]          row;
    logic                rd_v;      // an address was presented this cycle
    logic                dat_v;     // memory data for dat_row is valid this cycle
    logic [2:0]          dat_row;
    logic [LANES*LW-1:0] upd_word;

    // One lane: product, floor shift, widened subtract, saturate to LW bits.
    function automatic logic [LW-1:0] upd_lane(input logic signed [LW-1:0] r,
                                               input logic signed [LW-1:0] phi,
                                               input logic signed [LW-1:0] c);
        logic signed [2*LW-1:0] p;
        logic signed [2*LW-1:0] q;
        logic signed [2*LW:0]   d;
        p = c * phi;
        q = p >>> FRAC;
        d = (2*LW+1)'(r) - (2*LW+1)'(q);
        if (d > (2*LW+1)'(32767))
            upd_lane = 16'h7FFF;
        else if (d < -(2*LW+1)'(32768))
            upd_lane = 16'h8000;
        else
            upd_lane = d[LW-1:0];
    endfunction

    // Combinational per-lane update of the row whose data is currently valid.
    always_comb begin
        upd_word = '0;
        for (int i = 0; i < LANES; i++) begin
            upd_word[i*LW +: LW] = upd_lane(r_rd_data[i*LW +: LW],
                                            phi_data[i*LW +: LW],
                                            coef_q);
        end
    end

    // Control FSM, read-issue pipeline and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lambda_q     <= '0;
            coef_q       <= '0;
            m_q          <= '0;
            row          <= '0;
            rd_v         <= 1'b0;
            dat_v        <= 1'b0;
            dat_row      <= '0;
            phi_addr     <= '0;
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_we         <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            block_r_done <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            block_r_done <= 1'b0;
            dat_v        <= rd_v;
            dat_row      <= row;
            if (dat_v) begin
                r_we      <= 1'b1;
                r_wr_addr <= dat_row;
                r_wr_data <= upd_word;
            end
            case (state)
                S_IDLE: begin
                    // the done cycle itself does not accept a new start
                    if (start_c && !block_r_done) begin
                        lambda_q <= lambda;
                        coef_q   <= coef;
                        m_q      <= M;
                        busy     <= 1'b1;
                        err      <= (lambda > N);
                        if (lambda > N) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_RUN;
                            row       <= 3'd0;
                            phi_addr  <= {lambda, 3'd0};
                            r_rd_addr <= 3'd0;
                            rd_v      <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (row == m_q) begin
                        rd_v  <= 1'b0;
                        state <= S_DRAIN;
                    end else begin
                        row       <= row + 3'd1;
                        phi_addr  <= {lambda_q, row + 3'd1};
                        r_rd_addr <= row + 3'd1;
                    end
                end
                S_DRAIN: begin
                    if (dat_v)
                        state <= S_DONE;
                end
                S_DONE: begin
                    block_r_done <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_r_update.sv
// Directed bench for block_r_update with behavioural phi/r memories.
module tb_block_r_update;

    logic        clk = 1'b0;
    logic        rst_n, start_c;
    logic [5:0]  N, lambda;
    logic [2:0]  M;
    logic [15:0] coef;
    logic [8:0]  phi_addr;
    logic [95:0] phi_data, r_rd_data, r_wr_data;
    logic [2:0]  r_rd_addr, r_wr_addr;
    logic        r_we, busy, err, block_r_done;

    block_r_update dut (
        .clk(clk), .rst_n(rst_n), .start_c(start_c), .N(N), .M(M),
        .lambda(lambda), .coef(coef), .phi_addr(phi_addr), .phi_data(phi_data),
        .r_rd_addr(r_rd_addr), .r_rd_data(r_rd_data), .r_wr_addr(r_wr_addr),
        .r_wr_data(r_wr_data), .r_we(r_we), .busy(busy), .err(err),
        .block_r_done(block_r_done)
    );

    always #5 clk = ~clk;

    logic [95:0] phi_mem [512];
    logic [95:0] r_mem [8];

    // memories with one-cycle read latency
    always @(posedge clk) begin
        phi_data  <= phi_mem[phi_addr];
        r_rd_data <= r_mem[r_rd_addr];
        if (r_we) r_mem[r_wr_addr] <= r_wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  wr_addr_log [16];
    logic [95:0] wr_data_log [16];
    int          wr_edge_log [16];
    int          nwr = 0, ndone = 0, done_edge = -1, e0 = 0;

    // write / done logger, sampled away from the active edge
    always @(negedge clk) begin
        if (r_we && nwr < 16) begin
            wr_addr_log[nwr] = r_wr_addr;
            wr_data_log[nwr] = r_wr_data;
            wr_edge_log[nwr] = cyc;
            nwr++;
        end
        if (block_r_done) begin
            if (ndone == 0) done_edge = cyc;
            ndone++;
        end
    end

    int passed = 0, total = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic start_op(input logic [2:0] m, input logic [5:0] l,
                            input logic [15:0] c, input logic [5:0] n);
        @(negedge clk);
        M = m; lambda = l; coef = c; N = n; start_c = 1'b1;
        nwr = 0; ndone = 0; done_edge = -1;
        @(posedge clk); #1;
        start_c = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (ndone == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 96'(ndone > 0 ? 1 : 0), 96'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [95:0] orig [8];

    initial begin
        rst_n = 1'b0; start_c = 1'b0; N = '0; M = '0; lambda = '0; coef = '0;
        for (int i = 0; i < 512; i++) phi_mem[i] = '0;
        for (int i = 0; i < 8; i++) r_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_we", 96'(r_we), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_err", 96'(err), 96'd0);
        chk("rst_done", 96'(block_r_done), 96'd0);
        chk("rst_phi_addr", 96'(phi_addr), 96'd0);
        chk("rst_wr_data", r_wr_data, 96'd0);
        @(negedge clk) rst_n = 1'b1;

        // identity: coef 0 writes back the rows unchanged
        r_mem[0] = 96'h0123_4567_89AB_CDEF_1357_9BDF;
        r_mem[1] = 96'hFEDC_BA98_7654_3210_2468_ACE0;
        phi_mem[40] = {6{16'h4000}};
        phi_mem[41] = {6{16'h2345}};
        start_op(3'd1, 6'd5, 16'h0000, 6'd63);
        chk("id_phi_addr0", 96'(phi_addr), 96'd40);
        chk("id_busy", 96'(busy), 96'd1);
        @(posedge clk); #1;
        chk("id_phi_addr1", 96'(phi_addr), 96'd41);
        wait_done(20);
        chk("id_nwr", 96'(nwr), 96'd2);
        chk("id_addr0", 96'(wr_addr_log[0]), 96'd0);
        chk("id_addr1", 96'(wr_addr_log[1]), 96'd1);
        chk("id_data0", wr_data_log[0], 96'h0123_4567_89AB_CDEF_1357_9BDF);
        chk("id_data1", wr_data_log[1], 96'hFEDC_BA98_7654_3210_2468_ACE0);
        chk("id_wr_edge0", 96'(wr_edge_log[0] - e0), 96'd2);
        chk("id_wr_edge1", 96'(wr_edge_log[1] - e0), 96'd3);
        chk("id_done_edge", 96'(done_edge - e0), 96'd4);
        chk("id_done_count", 96'(ndone), 96'd1);

        // basic update: 0x1000 - 0.5*1.0 -> 0xF000
        phi_mem[16] = {6{16'h4000}}; phi_mem[17] = {6{16'h4000}};
        r_mem[0] = {6{16'h1000}};    r_mem[1] = {6{16'h1000}};
        start_op(3'd1, 6'd2, 16'h2000, 6'd63);
        wait_done(20);
        chk("basic_data0", wr_data_log[0], {6{16'hF000}});
        chk("basic_data1", wr_data_log[1], {6{16'hF000}});

        // negative saturation
        phi_mem[24] = {6{16'h4000}}; phi_mem[25] = {6{16'h4000}};
        r_mem[0] = {6{16'h8000}};    r_mem[1] = {6{16'h8000}};
        start_op(3'd1, 6'd3, 16'h4000, 6'd63);
        wait_done(20);
        chk("satn_data0", wr_data_log[0], {6{16'h8000}});
        chk("satn_data1", wr_data_log[1], {6{16'h8000}});

        // positive saturation
        phi_mem[32] = {6{16'h4000}}; phi_mem[33] = {6{16'h4000}};
        r_mem[0] = {6{16'h7000}};    r_mem[1] = {6{16'h7000}};
        start_op(3'd1, 6'd4, 16'hC000, 6'd63);
        wait_done(20);
        chk("satp_data0", wr_data_log[0], {6{16'h7FFF}});
        chk("satp_data1", wr_data_log[1], {6{16'h7FFF}});

        // floor shift on row 0; distinct lanes on row 1
        phi_mem[48] = {6{16'hFFFF}}; r_mem[0] = '0;
        phi_mem[49] = {6{16'h4000}}; r_mem[1] = 96'h0500_0400_0300_0200_0100_0000;
        start_op(3'd1, 6'd6, 16'h0001, 6'd63);
        wait_done(20);
        chk("floor_data0", wr_data_log[0], {6{16'h0001}});
        chk("lanes_data1", wr_data_log[1], 96'h04FF_03FF_02FF_01FF_00FF_FFFF);

        // full run, with a second start and port changes mid-run
        for (int k = 0; k < 8; k++) begin
            phi_mem[504 + k] = {6{16'h4000}};
            orig[k] = {6{16'(16'h0111 * (k + 1))}};
            r_mem[k] = orig[k];
        end
        start_op(3'd7, 6'd63, 16'h0000, 6'd63);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_phi_addr%0d", k), 96'(phi_addr), 96'(504 + k));
            chk($sformatf("full_rd_addr%0d", k), 96'(r_rd_addr), 96'(k));
            if (k == 2) begin
                @(negedge clk);
                start_c = 1'b1; lambda = 6'd1; M = 3'd1; coef = 16'h4000;
            end
            @(posedge clk); #1;
            start_c = 1'b0;
        end
        wait_done(20);
        chk("full_nwr", 96'(nwr), 96'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full_addr%0d", k), 96'(wr_addr_log[k]), 96'(k));
            chk($sformatf("full_data%0d", k), wr_data_log[k], orig[k]);
        end
        chk("full_done_edge", 96'(done_edge - e0), 96'd10);
        chk("full_done_count", 96'(ndone), 96'd1);

        // lambda out of range
        start_op(3'd1, 6'd20, 16'h1234, 6'd15);
        chk("err_set", 96'(err), 96'd1);
        wait_done(20);
        chk("err_done_edge", 96'(done_edge - e0), 96'd1);
        chk("err_nwr", 96'(nwr), 96'd0);
        start_op(3'd1, 6'd5, 16'h0000, 6'd63);
        chk("err_cleared", 96'(err), 96'd0);
        wait_done(20);

        // reset in the middle of an M=7 run
        start_op(3'd7, 6'd63, 16'h0000, 6'd63);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_r_we", 96'(r_we), 96'd0);
        chk("rstmid_busy", 96'(busy), 96'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("rstmid_nwr", 96'(nwr), 96'd2);
        chk("rstmid_no_done", 96'(ndone), 96'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/block_r_update.md
Name: block_r_update

Overview:
- Writer side of the residual BRAM (r_bram); block_a_top reads the same memory on its read port.
- After atom selection, the block applies r[k] := r[k] - coef * phi_lambda[k] for rows k = 0..M.
- It reads phi column lambda and the current residual rows, and writes the updated rows back through r_bram port A.
- A top-level FSM starts it after block_a_top and before the next block_a_top run.

Parameters:
- LANES, 6, signed lanes packed per 96-bit word; lane i occupies bits [16i+15:16i].
- LW, 16, lane width in bits (signed two's complement).
- FRAC, 14, fractional bits of phi, r and coef (Q2.14).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start_c  in  1  single-cycle start pulse.
- N  in  6  DRI atom count (15 or 63); used only for the lambda range check.
- M  in  3  DRI last row index (1 or 7); rows processed = M+1.
- lambda  in  6  selected atom index.
- coef  in  16  signed Q2.14 update coefficient.
- phi_addr  out  9  phi_bram read address = {lambda, row[2:0]}.
- phi_data  in  96  phi_bram read data, 1-cycle latency.
- r_rd_addr  out  3  r_bram read address.
- r_rd_data  in  96  r_bram read data, 1-cycle latency.
- r_wr_addr  out  3  r_bram port A write address.
- r_wr_data  out  96  r_bram port A write data.
- r_we  out  1  r_bram port A write enable.
- busy  out  1  high from the cycle after start is accepted until done.
- err  out  1  sticky; set when lambda > N is sampled at start.
- block_r_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0 at an edge): state S_IDLE; all outputs 0 (addresses, r_wr_data, r_we, busy, err, block_r_done); row counters 0.
- Reset mid-operation: takes effect on the next edge, r_we=0 from that edge, no further writes, and done is never pulsed.
- States are S_IDLE, S_RUN, S_DRAIN and S_DONE.
- S_IDLE:
  - start_c=1 latches lambda, coef and M into internal registers, clears err, and moves to S_RUN.
  - If lambda > N at that edge, err is set and the state goes directly to S_DONE. No reads or writes occur.
- Let E0 be the start edge. Rows are read in order 0..M, one per cycle.
- Row k timing:
  - Addresses are presented after edge E_k.
  - Data is valid after E_{k+1}.
  - r_wr_data, r_wr_addr=k and r_we=1 are registered at E_{k+2}; the write commits at E_{k+3}.
- S_RUN issues rows 0..M. After the last issue it moves to S_DRAIN, which holds until the last write is presented. It then moves to S_DONE.
- S_DONE: block_r_done=1 for exactly one cycle, presented after E_{M+3} (the cycle after the last r_we cycle), then S_IDLE.
- busy is low in that done cycle.
- Throughput is 1 row/cycle.
- Reading row k+2 while writing row k is allowed: the addresses always differ, so there is no read-after-write hazard.
- Per-lane arithmetic:
  - p = coef * phi_lane, 32-bit signed.
  - q = p >>> FRAC (arithmetic shift, floor, no rounding).
  - d = r_lane - q, computed at 33 bits.
  - Saturate d to [-32768, 32767].
- start_c while busy is ignored: latched values do not change and no restart occurs.
- start_c in the S_DONE cycle is also ignored.
- Between writes, r_wr_addr and r_wr_data hold their last values and r_we=0.
- Latched M and lambda are used for the whole run; changes on the input ports mid-run have no effect.

Test Plan:
- Identity: M=1, lambda=5, coef=0x0000 → phi_addr 40 then 41; two writes at addresses 0 and 1 with data equal to the previously read r words; done one cycle after the second write; 4 cycles E0→done.
- Basic update: all lanes r=0x1000, phi=0x4000, coef=0x2000, M=1 → every written lane 0xF000 (-4096).
- Saturation, negative: r=0x8000, phi=0x4000, coef=0x4000 → 0x8000.
- Saturation, positive: r=0x7000, phi=0x4000, coef=0xC000 → 0x7FFF.
- Floor check: coef=0x0001, phi=0xFFFF, r=0 → q=-1, so 0x0001 is written.
- Full run and robustness:
  - M=7, lambda=63, N=63 → phi_addr 504..511 consecutively; 8 writes at addresses 0..7; done after E10.
  - A second start_c at E3 is ignored.
  - lambda=20 with N=15 → err=1, no r_we, done after E1.
  - rst_n=0 at E4 of an M=7 run → r_we=0 from E4 onward, no done pulse.
